// File: rtl/icache_pipelined.sv
// Pipelined, run-time loadable instruction store returning one cache line per request.
// Requests are credit-limited so the in-order response queue can never overflow.
module icache_pipelined #(
    parameter int DEPTH_WORDS = 128,
    parameter int CL_WORDS    = 4,
    parameter int LATENCY     = 1,
    parameter int RSP_Q_DEPTH = 4,
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ID_W-1:0]                req_id,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [CL_WORDS*32-1:0]         rsp_data,
    output logic                           rsp_err,
    input  logic                           ld_valid,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int DATA_W = CL_WORDS * 32;
    localparam int QP_W   = (RSP_Q_DEPTH > 1) ? $clog2(RSP_Q_DEPTH) : 1;
    localparam int OCC_W  = $clog2(RSP_Q_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              err;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [31:0]      mem_q [DEPTH_WORDS];
    entry_t           queue_q [RSP_Q_DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] cnt_q, cnt_d;
    logic [QP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [QP_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic             accept;
    logic             pop;
    logic [IDX_W-1:0] idx;
    logic             addr_err;
    entry_t           rd_entry;
    entry_t           q_in;
    logic             q_in_valid;
    entry_t           head;
    logic             unused_addr_bits;

    function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
        return (p == QP_W'(RSP_Q_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr_bits = ^req_addr[1:0];
    assign idx       = req_addr[2 +: IDX_W];
    assign addr_err  = |req_addr[ADDR_W-1:2+IDX_W];
    assign req_ready = (occ_q < OCC_W'(RSP_Q_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign head      = queue_q[rd_ptr_q];

    // Line read happens at the accept edge; this edge's load is not yet visible (read-before-write).
    always_comb begin
        rd_entry      = '0;
        rd_entry.id   = req_id;
        rd_entry.err  = addr_err;
        if (!addr_err) begin
            for (int w = 0; w < CL_WORDS; w++) begin
                rd_entry.data[32*w +: 32] = mem_q[idx + IDX_W'(w)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_valid) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign q_in_valid = accept;
            assign q_in       = rd_entry;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld_q, vld_d;
            entry_t             ent_q [LATENCY-1];
            entry_t             ent_d [LATENCY-1];

            always_comb begin
                vld_d[0] = accept;
                ent_d[0] = rd_entry;
                for (int k = 1; k < LATENCY - 1; k++) begin
                    vld_d[k] = vld_q[k-1];
                    ent_d[k] = ent_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            always_ff @(posedge clk) begin
                ent_q <= ent_d;
            end

            assign q_in_valid = vld_q[LATENCY-2];
            assign q_in       = ent_q[LATENCY-2];
        end
    endgenerate

    // occ counts pipeline plus queue, so a free credit always implies a free queue slot.
    always_comb begin
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && pop) begin
            occ_d = occ_q - 1'b1;
        end
        if (q_in_valid && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!q_in_valid && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (q_in_valid) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (q_in_valid) begin
            queue_q[wr_ptr_q] <= q_in;
        end
    end

    // Masking with rsp_valid gives zero outputs when empty, including right after async reset.
    always_comb begin
        rsp_id   = rsp_valid ? head.id   : '0;
        rsp_data = rsp_valid ? head.data : '0;
        rsp_err  = rsp_valid ? head.err  : 1'b0;
    end
endmodule

// File: tb/tb_icache_pipelined.sv
// Self-checking bench for icache_pipelined: directed scenarios plus random traffic
// compared against a queue-based reference model of the line store.
module tb_icache_pipelined;
    localparam int DEPTH_WORDS = 128;
    localparam int CL_WORDS    = 4;
    localparam int LATENCY     = 3;
    localparam int RSP_Q_DEPTH = 4;
    localparam int ADDR_W      = 32;
    localparam int ID_W        = 4;
    localparam logic [31:0] WORD_A = 32'hA0A0_0010;
    localparam logic [31:0] WORD_B = 32'hB0B0_0010;

    logic                   clk;
    logic                   reset_n;
    logic                   req_valid;
    logic                   req_ready;
    logic [ID_W-1:0]        req_id;
    logic [ADDR_W-1:0]      req_addr;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [CL_WORDS*32-1:0] rsp_data;
    logic                   rsp_err;
    logic                   ld_valid;
    logic [6:0]             ld_addr;
    logic [31:0]            ld_data;

    typedef struct {
        logic [ID_W-1:0]        id;
        logic [CL_WORDS*32-1:0] data;
        logic                   err;
        int                     avail;
    } exp_t;

    logic [31:0] mem_m [DEPTH_WORDS];
    exp_t        exp_q [$];
    int          edge_n;
    int          n_compared;
    int          n_mismatch;

    icache_pipelined #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .CL_WORDS   (CL_WORDS),
        .LATENCY    (LATENCY),
        .RSP_Q_DEPTH(RSP_Q_DEPTH),
        .ADDR_W     (ADDR_W),
        .ID_W       (ID_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_id   (req_id),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatch++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A line is CL_WORDS consecutive words from the word index, wrapping at the array end.
    function automatic exp_t modelRead(input logic [ID_W-1:0] id, input logic [31:0] addr);
        exp_t e;
        int   idx;
        e.id    = id;
        e.data  = '0;
        e.avail = 0;
        e.err   = (addr[31:9] != 23'd0);
        idx     = int'(addr[8:2]);
        if (!e.err) begin
            for (int w = 0; w < CL_WORDS; w++) begin
                e.data[32*w +: 32] = mem_m[(idx + w) % DEPTH_WORDS];
            end
        end
        return e;
    endfunction

    // Called at a negedge with inputs already driven; checks outputs, then advances one edge.
    task automatic applyStimulus();
        logic exp_valid;
        logic accept;
        logic pop;
        exp_t ent;
        exp_valid = (exp_q.size() > 0) && (exp_q[0].avail <= edge_n);
        checkOutput("req_ready", req_ready, exp_q.size() < RSP_Q_DEPTH);
        checkOutput("rsp_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("rsp_id", rsp_id, exp_q[0].id);
            checkOutput("rsp_data", rsp_data, exp_q[0].data);
            checkOutput("rsp_err", rsp_err, exp_q[0].err);
        end
        accept = req_valid && (exp_q.size() < RSP_Q_DEPTH);
        pop    = exp_valid && rsp_ready;
        ent    = modelRead(req_id, req_addr);
        @(posedge clk);
        edge_n++;
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (accept) begin
            ent.avail = edge_n + LATENCY - 1;
            exp_q.push_back(ent);
        end
        if (ld_valid) begin
            mem_m[ld_addr] = ld_data;
        end
        @(negedge clk);
    endtask

    task automatic idleSteps(input int n);
        req_valid = 1'b0;
        ld_valid  = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus();
        end
    endtask

    initial begin
        n_compared = 0;
        n_mismatch = 0;
        edge_n     = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_id     = '0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;

        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1'b1);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_rsp_id", rsp_id, '0);
        checkOutput("reset_rsp_data", rsp_data, '0);
        checkOutput("reset_rsp_err", rsp_err, 1'b0);
        reset_n = 1'b1;

        $display("[TB] loading array");
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            ld_valid = 1'b1;
            ld_addr  = 7'(i);
            if (i < 8) ld_data = 32'h1000 + 32'(i);
            else if (i == 10) ld_data = WORD_A;
            else ld_data = $urandom;
            applyStimulus();
        end
        ld_valid = 1'b0;

        $display("[TB] latency and data");
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_id    = 4'd5;
        req_addr  = 32'h8;
        applyStimulus();
        idleSteps(2);
        checkOutput("lat_valid", rsp_valid, 1'b1);
        checkOutput("lat_id", rsp_id, 4'd5);
        checkOutput("lat_data", rsp_data, {32'h1005, 32'h1004, 32'h1003, 32'h1002});
        checkOutput("lat_err", rsp_err, 1'b0);
        idleSteps(2);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_id    = 4'(i);
            req_addr  = 32'(i * 4);
            applyStimulus();
        end
        checkOutput("bp_req_ready_low", req_ready, 1'b0);
        idleSteps(3);
        checkOutput("bp_head_id_stalled", rsp_id, 4'd0);
        rsp_ready = 1'b1;
        idleSteps(5);
        for (int i = 4; i < 6; i++) begin
            req_valid = 1'b1;
            req_id    = 4'(i);
            req_addr  = 32'(i * 4);
            applyStimulus();
        end
        idleSteps(5);

        $display("[TB] wrap-around");
        req_valid = 1'b1;
        req_id    = 4'd7;
        req_addr  = 32'h1F8;
        applyStimulus();
        idleSteps(2);
        checkOutput("wrap_data", rsp_data, {mem_m[1], mem_m[0], mem_m[127], mem_m[126]});
        idleSteps(2);

        $display("[TB] out of range");
        req_valid = 1'b1;
        req_id    = 4'd9;
        req_addr  = 32'h200;
        applyStimulus();
        req_id    = 4'd10;
        req_addr  = 32'h10;
        applyStimulus();
        idleSteps(1);
        checkOutput("oor_err", rsp_err, 1'b1);
        checkOutput("oor_data", rsp_data, '0);
        checkOutput("oor_id", rsp_id, 4'd9);
        idleSteps(1);
        checkOutput("after_oor_err", rsp_err, 1'b0);
        checkOutput("after_oor_data", rsp_data, {mem_m[7], mem_m[6], mem_m[5], mem_m[4]});
        idleSteps(2);

        $display("[TB] load/read collision");
        req_valid = 1'b1;
        req_id    = 4'd3;
        req_addr  = 32'h28;
        ld_valid  = 1'b1;
        ld_addr   = 7'd10;
        ld_data   = WORD_B;
        applyStimulus();
        ld_valid  = 1'b0;
        req_id    = 4'd4;
        applyStimulus();
        idleSteps(1);
        checkOutput("col_old_word", rsp_data[31:0], WORD_A);
        idleSteps(1);
        checkOutput("col_new_word", rsp_data[31:0], WORD_B);
        idleSteps(2);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_id    = 4'($urandom);
            if ($urandom_range(0, 7) == 0) req_addr = $urandom;
            else req_addr = {23'd0, 9'($urandom)};
            rsp_ready = ($urandom_range(0, 3) != 0);
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_addr   = 7'($urandom);
            ld_data   = $urandom;
            applyStimulus();
        end
        rsp_ready = 1'b1;
        idleSteps(10);

        $display("[TB] reset mid-operation");
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_id    = 4'(i + 1);
            req_addr  = {23'd0, 9'($urandom)};
            applyStimulus();
        end
        idleSteps(1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", rsp_valid, 1'b0);
        checkOutput("midrst_rsp_id", rsp_id, '0);
        checkOutput("midrst_rsp_data", rsp_data, '0);
        checkOutput("midrst_rsp_err", rsp_err, 1'b0);
        checkOutput("midrst_req_ready", req_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_id    = 4'd6;
        req_addr  = 32'h10;
        applyStimulus();
        idleSteps(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
